// File: rtl/apb_cfg_master.sv
// APB3 requester for the configuration register port.
// Turns write / read / poll commands into APB transfers and returns one response pulse per
// command. Every output is a register; the FSM updates outputs together with the state so that
// each output already holds the value belonging to the state being entered.

`ifndef REG_ADDRWIDTH
`define REG_ADDRWIDTH 32
`endif
`ifndef REG_DATAWIDTH
`define REG_DATAWIDTH 32
`endif

module apb_cfg_master #(
  parameter int unsigned ADDR_W     = `REG_ADDRWIDTH,
  parameter int unsigned DATA_W     = `REG_DATAWIDTH,
  parameter int unsigned POLL_LIMIT = 1024
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  // command side
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [DATA_W-1:0] cmd_mask,
  // response side
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  // APB side
  output logic [ADDR_W-1:0] PADDR,
  output logic              PWRITE,
  output logic              PSEL,
  output logic              PENABLE,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY
);

  localparam int unsigned     CntW    = $clog2(POLL_LIMIT + 1);
  localparam logic [CntW-1:0] PollMax = CntW'(POLL_LIMIT);

  localparam logic [1:0] OpWrite = 2'b00;
  localparam logic [1:0] OpRead  = 2'b01;
  localparam logic [1:0] OpRsvd  = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StAccess,
    StGap,
    StResp
  } state_e;

  state_e            state_q;
  logic [1:0]        op_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] mask_q;
  logic [CntW-1:0]   cnt_q;

  logic [CntW-1:0]   cnt_inc;
  logic              poll_hit;
  logic              poll_exhausted;

  // Poll evaluation for the read completing this cycle; the attempt count saturates.
  always_comb begin
    cnt_inc        = (cnt_q == PollMax) ? cnt_q : cnt_q + CntW'(1);
    poll_hit       = ((PRDATA & mask_q) == (wdata_q & mask_q));
    poll_exhausted = (cnt_inc == PollMax);
  end

  // Command FSM with registered APB and response outputs.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q   <= StIdle;
      op_q      <= 2'b00;
      wdata_q   <= '0;
      mask_q    <= '0;
      cnt_q     <= '0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      PADDR     <= '0;
      PWRITE    <= 1'b0;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWDATA    <= '0;
    end else begin
      rsp_valid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            op_q      <= cmd_op;
            wdata_q   <= cmd_wdata;
            mask_q    <= cmd_mask;
            cnt_q     <= '0;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            if (cmd_op == OpRsvd) begin
              // Reserved op idles one cycle in GAP (no PSEL) so its response lands at T+2.
              state_q <= StGap;
            end else begin
              state_q <= StSetup;
              PSEL    <= 1'b1;
              PADDR   <= cmd_addr;
              PWRITE  <= (cmd_op == OpWrite);
              PWDATA  <= (cmd_op == OpWrite) ? cmd_wdata : '0;
            end
          end
        end

        StSetup: begin
          PENABLE <= 1'b1;
          state_q <= StAccess;
        end

        StAccess: begin
          if (PREADY) begin
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            case (op_q)
              OpWrite: begin
                rsp_rdata <= '0;
                rsp_err   <= 1'b0;
                rsp_valid <= 1'b1;
                state_q   <= StResp;
              end
              OpRead: begin
                rsp_rdata <= PRDATA;
                rsp_err   <= 1'b0;
                rsp_valid <= 1'b1;
                state_q   <= StResp;
              end
              default: begin
                cnt_q <= cnt_inc;
                if (poll_hit || poll_exhausted) begin
                  rsp_rdata <= PRDATA;
                  rsp_err   <= !poll_hit;
                  rsp_valid <= 1'b1;
                  state_q   <= StResp;
                end else begin
                  state_q <= StGap;
                end
              end
            endcase
          end
        end

        StGap: begin
          if (op_q == OpRsvd) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            state_q   <= StResp;
          end else begin
            // Next poll attempt; address and direction are still held from the first SETUP.
            PSEL    <= 1'b1;
            state_q <= StSetup;
          end
        end

        StResp: begin
          state_q   <= StIdle;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          PADDR     <= '0;
          PWRITE    <= 1'b0;
          PWDATA    <= '0;
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_cfg_master.sv
// Bench for apb_cfg_master: directed commands, a scoreboard of expected responses consumed by a
// response monitor, and an APB completer model that also checks bus-phase behaviour.

module tb_apb_cfg_master;

  logic        PCLK;
  logic        PRESETn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [31:0] cmd_mask;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;
  logic [31:0] PADDR;
  logic        PWRITE;
  logic        PSEL;
  logic        PENABLE;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;

  apb_cfg_master #(
    .ADDR_W    (32),
    .DATA_W    (32),
    .POLL_LIMIT(4)
  ) dut (
    .PCLK     (PCLK),
    .PRESETn  (PRESETn),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .cmd_mask (cmd_mask),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .busy     (busy),
    .PADDR    (PADDR),
    .PWRITE   (PWRITE),
    .PSEL     (PSEL),
    .PENABLE  (PENABLE),
    .PWDATA   (PWDATA),
    .PRDATA   (PRDATA),
    .PREADY   (PREADY)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  int cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  typedef struct {
    int          tag;
    logic [31:0] rdata;
    logic        err;
    bit          chk_rdata;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];

  always @(negedge PCLK) begin : rsp_monitor
    exp_t e;
    if (rsp_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("rsp_unexpected", 32'(rsp_valid), 32'd0);
      end else begin
        e = sb_q.pop_front();
        check($sformatf("rsp%0d_cycle", e.tag), cyc, e.cyc);
        check($sformatf("rsp%0d_err", e.tag), 32'(rsp_err), 32'(e.err));
        if (e.chk_rdata) check($sformatf("rsp%0d_rdata", e.tag), rsp_rdata, e.rdata);
      end
    end
  end

  // ---------------- APB completer model + bus checks ----------------
  int          wait_cfg   = 0;
  int          bit_on     = 0;   // read number (1-based) from which bit 31 is set; 0 = never
  logic [31:0] rd_base    = '0;
  int          reads_done = 0;
  int          n_setup    = 0;
  int          acc_cnt    = 0;
  int          last_setup_cyc = 0;
  int          last_done_cyc  = 0;
  logic [31:0] p_addr, p_wdata, last_addr, last_wdata;
  logic        p_write, last_write;
  bit          done_prev = 1'b0;

  initial begin
    PREADY = 1'b0;
    PRDATA = '0;
  end

  always @(negedge PCLK) begin : apb_model
    if (done_prev) begin
      check("gap_after_transfer", 32'(PSEL), 32'd0);
      done_prev = 1'b0;
    end
    if (PENABLE === 1'b1) check("penable_implies_psel", 32'(PSEL), 32'd1);
    if (PSEL === 1'b1 && PENABLE === 1'b1) begin
      acc_cnt++;
      if (acc_cnt > 1) begin
        check("access_stable_addr", PADDR, p_addr);
        check("access_stable_write", 32'(PWRITE), 32'(p_write));
        check("access_stable_wdata", PWDATA, p_wdata);
      end
      p_addr  = PADDR;
      p_write = PWRITE;
      p_wdata = PWDATA;
      PREADY  = (acc_cnt > wait_cfg);
      PRDATA  = (bit_on != 0 && reads_done + 1 >= bit_on) ? (rd_base | 32'h8000_0000) : rd_base;
      if (PREADY) begin
        if (!PWRITE) reads_done++;
        last_addr     = PADDR;
        last_write    = PWRITE;
        last_wdata    = PWDATA;
        last_done_cyc = cyc;
        done_prev     = 1'b1;
      end
    end else begin
      acc_cnt = 0;
      PREADY  = 1'b0;
      if (PSEL === 1'b1) begin
        n_setup++;
        last_setup_cyc = cyc;
      end
    end
  end

  // ---------------- stimulus ----------------
  int setups_at_acc = 0;

  task automatic issue(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] mask, input int tag, input logic [31:0] exp_rdata,
                       input logic exp_err, input bit chk_rd, input int lat, output int acc);
    int n;
    @(negedge PCLK);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    cmd_mask  = mask;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 100) begin
      @(negedge PCLK);
      n++;
    end
    if (cmd_ready !== 1'b1) begin
      check($sformatf("cmd%0d_accept_timeout", tag), 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b0;
      acc = -1;
      return;
    end
    setups_at_acc = n_setup;
    @(posedge PCLK);
    #1;
    acc = cyc;
    sb_q.push_back('{tag: tag, rdata: exp_rdata, err: exp_err, chk_rdata: chk_rd,
                     cyc: acc + lat - 1});
    cmd_valid = 1'b0;
  endtask

  task automatic drain(input int tag);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(negedge PCLK);
      n++;
    end
    if (sb_q.size() != 0) begin
      check($sformatf("rsp%0d_timeout", tag), 32'(sb_q.size()), 32'd0);
      sb_q.delete();
    end
    @(negedge PCLK);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int a, a2, s0;
    PRESETn   = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_addr  = '0;
    cmd_wdata = '0;
    cmd_mask  = '0;
    repeat (3) @(negedge PCLK);
    check("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_psel", 32'(PSEL), 32'd0);
    check("reset_penable", 32'(PENABLE), 32'd0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_err", 32'(rsp_err), 32'd0);
    check("reset_rsp_rdata", rsp_rdata, 32'd0);
    check("reset_paddr", PADDR, 32'd0);
    PRESETn = 1'b1;
    @(negedge PCLK);
    check("idle_cmd_ready", 32'(cmd_ready), 32'd1);

    // 1: zero-wait write
    wait_cfg = 0;
    s0 = n_setup;
    issue(2'b00, 32'h0, 32'h1, 32'h0, 1, 32'h0, 1'b0, 1'b1, 3, a);
    drain(1);
    check("wr_setup_cycle", last_setup_cyc, a);
    check("wr_access_cycle", last_done_cyc, a + 1);
    check("wr_pwrite", 32'(last_write), 32'd1);
    check("wr_pwdata", last_wdata, 32'h1);
    check("wr_transfers", n_setup - s0, 32'd1);

    // 2: read with two wait states
    wait_cfg = 2;
    rd_base  = 32'hDEAD_BEEF;
    bit_on   = 0;
    issue(2'b01, 32'h4, 32'h5555_5555, 32'h0, 2, 32'hDEAD_BEEF, 1'b0, 1'b1, 5, a);
    drain(2);
    check("rd_paddr", last_addr, 32'h4);
    check("rd_pwrite", 32'(last_write), 32'd0);
    check("rd_pwdata", last_wdata, 32'h0);
    check("rd_done_cycle", last_done_cyc, a + 3);

    // 3: poll that matches on the third read
    wait_cfg   = 0;
    rd_base    = 32'h0;
    bit_on     = 3;
    reads_done = 0;
    s0 = n_setup;
    issue(2'b10, 32'h0, 32'h8000_0000, 32'h8000_0000, 3, 32'h8000_0000, 1'b0, 1'b1, 9, a);
    drain(3);
    check("poll_match_transfers", n_setup - s0, 32'd3);
    check("poll_match_reads", reads_done, 32'd3);

    // 3b: zero mask matches on the first read
    rd_base = 32'h42;
    bit_on  = 0;
    s0 = n_setup;
    issue(2'b10, 32'h8, 32'hFFFF_FFFF, 32'h0, 4, 32'h42, 1'b0, 1'b1, 3, a);
    drain(4);
    check("poll_zero_mask_transfers", n_setup - s0, 32'd1);

    // 4: poll timeout after POLL_LIMIT = 4 reads
    rd_base = 32'hA5;
    bit_on  = 0;
    s0 = n_setup;
    issue(2'b10, 32'h0, 32'h8000_0000, 32'h8000_0000, 5, 32'hA5, 1'b1, 1'b1, 12, a);
    drain(5);
    check("poll_timeout_transfers", n_setup - s0, 32'd4);
    check("poll_timeout_busy_after", 32'(busy), 32'd0);
    check("poll_timeout_ready_after", 32'(cmd_ready), 32'd1);

    // 5: reserved op, then a read held during busy
    rd_base = 32'h1234_5678;
    s0 = n_setup;
    issue(2'b11, 32'h20, 32'h0, 32'h0, 6, 32'h0, 1'b1, 1'b0, 2, a);
    issue(2'b01, 32'h4, 32'h0, 32'h0, 7, 32'h1234_5678, 1'b0, 1'b1, 3, a2);
    check("rsvd_no_apb", setups_at_acc - s0, 32'd0);
    check("held_read_accept_cycle", a2, a + 3);
    drain(7);

    // 6: reset during ACCESS
    wait_cfg = 50;
    issue(2'b01, 32'hC, 32'h0, 32'h0, 8, 32'h0, 1'b0, 1'b0, 3, a);
    begin
      int n;
      n = 0;
      while (!(PSEL === 1'b1 && PENABLE === 1'b1) && n < 20) begin
        @(negedge PCLK);
        n++;
      end
      check("reach_access_before_reset", 32'(PENABLE), 32'd1);
    end
    PRESETn = 1'b0;
    sb_q.delete();
    @(negedge PCLK);
    check("midreset_psel", 32'(PSEL), 32'd0);
    check("midreset_penable", 32'(PENABLE), 32'd0);
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midreset_cmd_ready", 32'(cmd_ready), 32'd1);
    @(negedge PCLK);
    PRESETn  = 1'b1;
    wait_cfg = 0;
    issue(2'b00, 32'h10, 32'hCAFE_F00D, 32'h0, 9, 32'h0, 1'b0, 1'b1, 3, a);
    drain(9);
    check("post_reset_paddr", last_addr, 32'h10);
    check("post_reset_pwdata", last_wdata, 32'hCAFE_F00D);

    repeat (3) @(negedge PCLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
